// File: rtl/count_mon_pkg.sv
// Shared types and defaults for the count-change monitor.
package count_mon_pkg;

  localparam int CM_WIDTH         = 4;
  localparam int CM_DEPTH_DEFAULT = 8;

  // One logged change: the count value plus a flag marking a backward step.
  typedef struct packed {
    logic                wrap;
    logic [CM_WIDTH-1:0] count;
  } count_entry_t;

endpackage

// File: rtl/count_change_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a level count.
// The head entry is read straight from storage, so it appears the cycle after
// it was pushed and reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Gate requests: no pop while empty; push while full only alongside a pop.
  always_comb begin
    full    = (level == FULL_LEVEL);
    empty   = (level == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = empty ? '0 : mem[rd_ptr];
  end

  // Storage write; contents need no reset because rdata is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally modulo DEPTH; level tracks push/pop balance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/count_change_fifo.sv
// Logs every change of an upstream counter value into a small FIFO, tagging
// backward steps (wrap or counter reset) and flagging dropped changes.
module count_change_fifo
  import count_mon_pkg::*;
#(
  parameter int WIDTH = CM_WIDTH,
  parameter int DEPTH = CM_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_wrap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic             change;
  logic             wrap;
  logic             pop;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  logic [WIDTH:0]   head;

  // Change/wrap detection and the push/drop decision for this cycle.
  always_comb begin
    change    = !prev_valid || (count_in != prev);
    wrap      = prev_valid && (count_in < prev);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    push      = change && (!full || pop);
    drop      = change && full && !pop;
    out_wrap  = head[WIDTH];
    out_data  = head[WIDTH-1:0];
  end

  // Remember the last sampled count; reset invalidates it so the next value logs.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev       <= count_in;
      prev_valid <= 1'b1;
    end
  end

  // Sticky record that at least one change was lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({wrap, count_in}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_count_change_fifo.sv
// Directed bench with a queue scoreboard for count_change_fifo.
module tb_count_change_fifo;

  localparam int W = 4;
  localparam int D = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [W-1:0]          count_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [W-1:0]          out_data;
  logic                  out_wrap;
  logic [$clog2(D):0]    level;
  logic                  overflow;

  always #5 clk = ~clk;

  count_change_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_in  (count_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .level     (level),
    .overflow  (overflow)
  );

  logic [W:0]   sb_q[$];
  bit           m_pv;
  logic [W-1:0] m_prev;
  bit           m_ovf;
  int           n_checks;
  int           n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs against the scoreboard mid-cycle, then drive the next
  // inputs and advance the model to what the coming edge should produce.
  task automatic step(input logic [W-1:0] c, input logic r, input logic rs);
    bit popf, chg, wr;
    @(negedge clk);
    chk("valid", out_valid, (sb_q.size() != 0));
    chk("level", level, sb_q.size());
    chk("overflow", overflow, m_ovf);
    if (sb_q.size() != 0) begin
      chk("data", out_data, sb_q[0][W-1:0]);
      chk("wrap", out_wrap, sb_q[0][W]);
    end else begin
      chk("data_empty", out_data, 0);
      chk("wrap_empty", out_wrap, 0);
    end
    count_in  = c;
    out_ready = r;
    reset     = rs;
    if (rs) begin
      sb_q.delete();
      m_pv   = 0;
      m_prev = '0;
      m_ovf  = 0;
    end else begin
      popf = (sb_q.size() != 0) && r;
      chg  = !m_pv || (c != m_prev);
      wr   = m_pv && (c < m_prev);
      if (popf) void'(sb_q.pop_front());
      if (chg) begin
        if (sb_q.size() < D) sb_q.push_back({wr, c});
        else m_ovf = 1;
      end
      m_pv   = 1;
      m_prev = c;
    end
  endtask

  // Check state right after the edge that follows the last step, without
  // consuming a cycle (inputs stay as the last step left them).
  task automatic peek(input string tag, input int lvl, input bit ovf, input bit vld);
    @(posedge clk);
    #1;
    chk({tag, "_level"}, level, lvl);
    chk({tag, "_overflow"}, overflow, ovf);
    chk({tag, "_valid"}, out_valid, vld);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_pv     = 0;
    m_prev   = '0;
    m_ovf    = 0;
    reset     = 1'b1;
    count_in  = '0;
    out_ready = 1'b0;

    // T1: two reset cycles, then count 0 with ready -> single entry, then quiet.
    repeat (2) @(posedge clk);
    step(4'd0, 1'b1, 1'b0);
    peek("t1_first", 1, 0, 1);
    repeat (5) step(4'd0, 1'b1, 1'b0);

    // T2: 0,1..15,0 with ready -> 17 entries, wrap only on the last 0.
    step(4'd0, 1'b0, 1'b1);
    for (int i = 0; i <= 15; i++) step(W'(i), 1'b1, 1'b0);
    step(4'd0, 1'b1, 1'b0);
    peek("t2_wrap_head", 1, 0, 1);
    chk("t2_wrap_flag", out_wrap, 1);
    repeat (3) step(4'd0, 1'b1, 1'b0);

    // T3: no ready, 1..9 -> full with overflow; drain yields 1..8.
    step(4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) step(W'(i), 1'b0, 1'b0);
    peek("t3_full", 8, 1, 1);
    repeat (10) step(4'd9, 1'b1, 1'b0);

    // T4: full, then a new value together with a pop -> level stays 8, no overflow.
    step(4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) step(W'(i), 1'b0, 1'b0);
    peek("t4_full", 8, 0, 1);
    step(4'd12, 1'b1, 1'b0);
    peek("t4_pushpop", 8, 0, 1);
    repeat (10) step(4'd12, 1'b1, 1'b0);

    // T5: level 5, one reset cycle clears everything; next value has wrap=0.
    step(4'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) step(W'(i), 1'b0, 1'b0);
    peek("t5_pre", 5, 0, 1);
    step(4'd5, 1'b0, 1'b1);
    peek("t5_reset", 0, 0, 0);
    step(4'd3, 1'b1, 1'b0);
    peek("t5_after", 1, 0, 1);
    chk("t5_wrap", out_wrap, 0);
    repeat (3) step(4'd3, 1'b1, 1'b0);

    // T6: hold 7 for 20 cycles with no ready -> one entry, stable head.
    step(4'd0, 1'b0, 1'b1);
    repeat (21) step(4'd7, 1'b0, 1'b0);
    peek("t6_hold", 1, 0, 1);
    chk("t6_data", out_data, 7);
    repeat (3) step(4'd7, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
